q_eng_dispatch: RTL and testbench



---
 rtl/q_pkg.sv | 22 ++
 rtl/q_rr_pick.sv | 35 +++
 rtl/q_eng_dispatch.sv | 138 +++++++++++++
 tb/tb_q_eng_dispatch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// Shared types and default sizing for the q engine dispatch path.
package q_pkg;

    localparam int Q_ENGINES_N = 4;
    localparam int Q_ID_W      = 8;
    localparam int Q_OP_W      = 4;

    // One upstream command as carried on the dispatch interface.
    typedef struct packed {
        logic [Q_ID_W-1:0] id;
        logic [Q_OP_W-1:0] op;
    } cmd_t;

    // Dispatch control: RUN accepts work; DRAIN waits for the array to empty;
    // DRAINED holds the array quiet until the request is withdrawn.
    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } disp_state_e;

endpackage

// File: rtl/q_rr_pick.sv
// Combinational round-robin first-idle picker: searches the idle vector
// starting at rr_ptr and wrapping, returns one-hot grant, index and found flag.
module q_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     idle,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             found
);

    // Walk the N positions from rr_ptr upward; the first idle one wins.
    always_comb begin
        int                pos;
        logic [IDX_W-1:0]  p_idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        p_idx   = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N) pos = pos - N;
            p_idx = IDX_W'(pos);
            if (!found && idle[p_idx]) begin
                found         = 1'b1;
                gnt_oh[p_idx] = 1'b1;
                gnt_idx       = p_idx;
            end
        end
    end

endmodule

// File: rtl/q_eng_dispatch.sv
// Engine dispatch: accepts commands, issues each to one idle engine chosen
// round-robin, tracks per-engine busy until done, and supports quiesce.
module q_eng_dispatch
    import q_pkg::*;
#(
    parameter  int ENGINES_N = Q_ENGINES_N,
    parameter  int ID_W      = Q_ID_W,
    parameter  int OP_W      = Q_OP_W,
    localparam int IDX_W     = (ENGINES_N > 1) ? $clog2(ENGINES_N) : 1,
    localparam int CNT_W     = $clog2(ENGINES_N + 1)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 cmd_vld,
    input  logic [ID_W-1:0]      cmd_id,
    input  logic [OP_W-1:0]      cmd_op,
    output logic                 cmd_rdy,
    output logic [ENGINES_N-1:0] eng_issue_vld,
    output logic [ID_W-1:0]      eng_issue_id,
    output logic [OP_W-1:0]      eng_issue_op,
    input  logic [ENGINES_N-1:0] eng_done,
    input  logic                 drain_req,
    output logic                 drained,
    output logic [CNT_W-1:0]     inflight,
    output logic                 err
);

    disp_state_e          state_q, state_d;
    logic [ENGINES_N-1:0] busy_q;
    logic [ENGINES_N-1:0] issue_vld_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]      issue_id_q;
    logic [OP_W-1:0]      issue_op_q;
    logic [CNT_W-1:0]     inflight_q;
    logic                 err_q;
    logic                 drained_q, drained_d;

    logic [ENGINES_N-1:0] idle;
    logic [ENGINES_N-1:0] gnt_oh;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     rr_ptr_nxt;
    logic                 found;
    logic                 accept;
    logic [ENGINES_N-1:0] done_ok;
    logic [ENGINES_N-1:0] done_bad;
    logic [CNT_W-1:0]     n_done;

    assign idle = ~busy_q;

    q_rr_pick #(
        .N     (ENGINES_N),
        .IDX_W (IDX_W)
    ) u_pick (
        .idle    (idle),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .found   (found)
    );

    assign accept     = cmd_vld & cmd_rdy;
    // A done only counts against an engine that is actually busy; anything
    // else is a protocol error and must not disturb the bookkeeping.
    assign done_ok    = eng_done & busy_q;
    assign done_bad   = eng_done & ~busy_q;
    assign rr_ptr_nxt = (gnt_idx == IDX_W'(ENGINES_N - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // Number of legitimate completions this cycle.
    always_comb begin
        n_done = '0;
        for (int i = 0; i < ENGINES_N; i++) begin
            if (done_ok[i]) n_done = n_done + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    // FSM next state; withdrawing drain_req always wins over reaching idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req)                                   state_d = ST_RUN;
                else if (busy_q == '0 && issue_vld_q == '0)       state_d = ST_DRAINED;
            end
            ST_DRAINED: if (!drain_req) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // FSM outputs; cmd_rdy looks only at registered state, never cmd_vld.
    always_comb begin
        cmd_rdy   = (state_q == ST_RUN) && found;
        drained_d = (state_d == ST_DRAINED);
    end

    // drained is registered so it lines up with the DRAINED state itself.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) drained_q <= 1'b0;
        else         drained_q <= drained_d;
    end

    // Busy/issue/pointer/counter datapath; issue fields hold when idle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q      <= '0;
            issue_vld_q <= '0;
            rr_ptr_q    <= '0;
            issue_id_q  <= '0;
            issue_op_q  <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= (busy_q & ~done_ok) | (accept ? gnt_oh : '0);
            issue_vld_q <= accept ? gnt_oh : '0;
            inflight_q  <= inflight_q + CNT_W'(accept) - n_done;
            err_q       <= err_q | (|done_bad);
            if (accept) begin
                issue_id_q <= cmd_id;
                issue_op_q <= cmd_op;
                rr_ptr_q   <= rr_ptr_nxt;
            end
        end
    end

    assign eng_issue_vld = issue_vld_q;
    assign eng_issue_id  = issue_id_q;
    assign eng_issue_op  = issue_op_q;
    assign inflight      = inflight_q;
    assign err           = err_q;
    assign drained       = drained_q;

endmodule

// File: tb/tb_q_eng_dispatch.sv
// Bench for q_eng_dispatch: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the dispatch rules.
module tb_q_eng_dispatch;
    import q_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           cmd_vld = 1'b0;
    logic [7:0]     cmd_id = '0;
    logic [3:0]     cmd_op = '0;
    logic           cmd_rdy;
    logic [N-1:0]   eng_issue_vld;
    logic [7:0]     eng_issue_id;
    logic [3:0]     eng_issue_op;
    logic [N-1:0]   eng_done = '0;
    logic           drain_req = 1'b0;
    logic           drained;
    logic [IW-1:0]  inflight;
    logic           err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    q_eng_dispatch #(.ENGINES_N(N), .ID_W(8), .OP_W(4)) dut (
        .clk(clk), .arst_n(arst_n), .cmd_vld(cmd_vld), .cmd_id(cmd_id), .cmd_op(cmd_op),
        .cmd_rdy(cmd_rdy), .eng_issue_vld(eng_issue_vld), .eng_issue_id(eng_issue_id),
        .eng_issue_op(eng_issue_op), .eng_done(eng_done), .drain_req(drain_req),
        .drained(drained), .inflight(inflight), .err(err)
    );

    // ---------------- behavioural reference model ----------------
    bit   m_busy [N];
    int   m_ptr;
    int   m_iss;       // engine issued last edge, -1 if none
    cmd_t m_cmd;
    bit   m_err;
    int   m_stage;     // 0 running, 1 draining, 2 drained
    bit   m_hold;      // command presented but not taken last edge

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_ptr = 0; m_iss = -1; m_cmd = '0; m_err = 0; m_stage = 0; m_hold = 0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_rdy();
        return (m_stage == 0) && (m_count() < N);
    endfunction

    function automatic logic [N-1:0] m_iss_vec();
        logic [N-1:0] v = '0;
        if (m_iss >= 0) v[m_iss] = 1'b1;
        return v;
    endfunction

    // Apply one clock edge of the dispatch rules to the model.
    function automatic void m_step();
        bit acc;
        bit idle_now;
        int g = -1;
        acc = cmd_vld && m_rdy();
        if (acc) begin
            for (int k = 0; k < N; k++) begin
                int p = (m_ptr + k) % N;
                if (g < 0 && !m_busy[p]) g = p;
            end
        end
        idle_now = (m_count() == 0) && (m_iss < 0);
        case (m_stage)
            0: if (drain_req) m_stage = 1;
            1: if (!drain_req) m_stage = 0; else if (idle_now) m_stage = 2;
            2: if (!drain_req) m_stage = 0;
            default: m_stage = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (eng_done[i]) begin
                if (m_busy[i]) m_busy[i] = 0;
                else           m_err = 1;
            end
        end
        m_iss = -1;
        if (acc) begin
            m_busy[g] = 1;
            m_ptr     = (g + 1) % N;
            m_iss     = g;
            m_cmd.id  = cmd_id;
            m_cmd.op  = cmd_op;
        end
        m_hold = cmd_vld && !acc;
    endfunction

    // One clock: advance the model with the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    // Mid-cycle reset pulse, then realign to posedge+1.
    task automatic do_reset();
        #2 arst_n = 1'b0;
        m_reset();
        #2 arst_n = 1'b1;
        tick();
    endtask

    // Upstream protocol: a stalled command must stay stable while held.
    logic       p_hold = 1'b0;
    logic [7:0] p_id   = '0;
    logic [3:0] p_op   = '0;
    always @(posedge clk) begin
        if (arst_n && p_hold && cmd_vld)
            assert (cmd_id == p_id && cmd_op == p_op) else $error("upstream hold rule broken");
        p_hold <= cmd_vld && !cmd_rdy;
        p_id   <= cmd_id;
        p_op   <= cmd_op;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cmd_vld = 0; eng_done = '0; drain_req = 0;
        arst_n = 1'b0;
        m_reset();
        #12;
        checks++; if (eng_issue_vld !== 4'b0000) begin errors++; $display("FAIL reset_issue_vld got %b exp 0000", eng_issue_vld); end
        checks++; if (eng_issue_id !== 8'h00) begin errors++; $display("FAIL reset_issue_id got %h exp 00", eng_issue_id); end
        checks++; if (eng_issue_op !== 4'h0) begin errors++; $display("FAIL reset_issue_op got %h exp 0", eng_issue_op); end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got %b exp 0", drained); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy got %b exp 1", cmd_rdy); end
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int k = 0; k < 4; k++) begin
            op = 4'($urandom);
            cmd_vld = 1; cmd_id = 8'h10 + 8'(k); cmd_op = op;
            checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b exp 1", k, cmd_rdy); end
            tick();
            checks++; if (eng_issue_vld !== (4'b0001 << k)) begin errors++; $display("FAIL b2b_issue[%0d] got %b exp %b", k, eng_issue_vld, 4'b0001 << k); end
            checks++; if (eng_issue_id !== 8'h10 + 8'(k) || eng_issue_op !== op) begin errors++; $display("FAIL b2b_idop[%0d] got %h/%h exp %h/%h", k, eng_issue_id, eng_issue_op, 8'h10 + 8'(k), op); end
        end
        cmd_vld = 0;
        tick();
        checks++; if (eng_issue_vld !== 4'b0000) begin errors++; $display("FAIL b2b_strobe_drop got %b exp 0000", eng_issue_vld); end
        checks++; if (eng_issue_id !== 8'h13) begin errors++; $display("FAIL b2b_id_hold got %h exp 13", eng_issue_id); end
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL b2b_inflight got %0d exp 4", inflight); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full_rdy got %b exp 0", cmd_rdy); end
    endtask

    task automatic test_done_reopen();
        eng_done = 4'b0100;
        tick();
        eng_done = '0;
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reopen_rdy got %b exp 1", cmd_rdy); end
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL reopen_inflight got %0d exp 3", inflight); end
        cmd_vld = 1; cmd_id = 8'h20; cmd_op = 4'h5;
        tick();
        cmd_vld = 0;
        checks++; if (eng_issue_vld !== 4'b0100 || eng_issue_id !== 8'h20) begin errors++; $display("FAIL reopen_issue got %b/%h exp 0100/20", eng_issue_vld, eng_issue_id); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reopen_full got %b exp 0", cmd_rdy); end
        // Free 1 and 3 together: pointer at 3 must pick 3 before 1.
        eng_done = 4'b1010;
        tick();
        eng_done = '0;
        cmd_vld = 1; cmd_id = 8'h21; cmd_op = 4'h6;
        tick();
        cmd_vld = 0;
        checks++; if (eng_issue_vld !== 4'b1000) begin errors++; $display("FAIL rrptr_after_wrap got %b exp 1000", eng_issue_vld); end
    endtask

    task automatic test_done_and_accept();
        eng_done = 4'b0001;
        tick();
        eng_done = '0;
        cmd_vld = 1; cmd_id = 8'h30; cmd_op = 4'h1;
        tick();
        checks++; if (eng_issue_vld !== 4'b0001) begin errors++; $display("FAIL dna_setup got %b exp 0001", eng_issue_vld); end
        cmd_id = 8'h31; cmd_op = 4'h2; eng_done = 4'b1000;
        tick();
        eng_done = '0;
        checks++; if (eng_issue_vld !== 4'b0010) begin errors++; $display("FAIL dna_grant got %b exp 0010", eng_issue_vld); end
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL dna_inflight got %0d exp 3", inflight); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL dna_rdy got %b exp 1", cmd_rdy); end
        cmd_id = 8'h32; cmd_op = 4'h3;
        tick();
        cmd_vld = 0;
        checks++; if (eng_issue_vld !== 4'b1000 || inflight !== 3'd4) begin errors++; $display("FAIL dna_eng3 got %b/%0d exp 1000/4", eng_issue_vld, inflight); end
    endtask

    task automatic test_err();
        eng_done = 4'b0001;
        tick();
        checks++; if (err !== 1'b0 || inflight !== 3'd3) begin errors++; $display("FAIL err_valid_done got %b/%0d exp 0/3", err, inflight); end
        tick();
        eng_done = '0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL err_inflight got %0d exp 3", inflight); end
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_drain();
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err_cleared got %b exp 0", err); end
        cmd_vld = 1; cmd_id = 8'h40; tick();
        cmd_id = 8'h41; tick();
        cmd_vld = 0; drain_req = 1;
        tick();
        checks++; if (cmd_rdy !== 1'b0 || drained !== 1'b0) begin errors++; $display("FAIL drain_enter got rdy %b drained %b exp 0/0", cmd_rdy, drained); end
        eng_done = 4'b0001; tick();
        eng_done = 4'b0010; tick();
        eng_done = '0;
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_early got %b exp 0", drained); end
        tick();
        checks++; if (drained !== 1'b1 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL drain_done got drained %b rdy %b exp 1/0", drained, cmd_rdy); end
        drain_req = 0;
        tick();
        checks++; if (drained !== 1'b0 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL drain_exit got drained %b rdy %b exp 0/1", drained, cmd_rdy); end
        // Already idle: drained two edges after the request.
        drain_req = 1;
        tick();
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_idle_1 got %b exp 0", drained); end
        tick();
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL drain_idle_2 got %b exp 1", drained); end
        drain_req = 0;
        tick();
        // Request withdrawn while still draining.
        cmd_vld = 1; cmd_id = 8'h42; tick();
        cmd_vld = 0; drain_req = 1; tick();
        drain_req = 0; tick();
        checks++; if (cmd_rdy !== 1'b1 || drained !== 1'b0) begin errors++; $display("FAIL drain_abort got rdy %b drained %b exp 1/0", cmd_rdy, drained); end
        eng_done = 4'b0100; tick();
        eng_done = '0;
    endtask

    task automatic test_async_reset();
        cmd_vld = 1;
        for (int k = 0; k < 3; k++) begin
            cmd_id = 8'h48 + 8'(k); cmd_op = 4'(k); tick();
        end
        cmd_vld = 0;
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL arst_pre_inflight got %0d exp 3", inflight); end
        #2 arst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (eng_issue_vld !== 4'b0000 || inflight !== 3'd0 || err !== 1'b0 || drained !== 1'b0) begin errors++; $display("FAIL arst_async got vld %b infl %0d err %b dr %b exp 0000/0/0/0", eng_issue_vld, inflight, err, drained); end
        checks++; if (eng_issue_id !== 8'h00 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL arst_async_id got %h rdy %b exp 00/1", eng_issue_id, cmd_rdy); end
        #2 arst_n = 1'b1;
        tick();
        cmd_vld = 1; cmd_id = 8'h50; cmd_op = 4'h7;
        tick();
        cmd_vld = 0;
        checks++; if (eng_issue_vld !== 4'b0001) begin errors++; $display("FAIL arst_first_grant got %b exp 0001", eng_issue_vld); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!m_hold) begin
                cmd_vld = ($urandom_range(0, 2) != 0);
                cmd_id  = 8'($urandom);
                cmd_op  = 4'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                eng_done[i] = m_busy[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            end
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            checks++; if (cmd_rdy !== m_rdy()) begin errors++; $display("FAIL rnd_rdy@%0d got %b exp %b", c, cmd_rdy, m_rdy()); end
            tick();
            checks++; if (eng_issue_vld !== m_iss_vec()) begin errors++; $display("FAIL rnd_issue@%0d got %b exp %b", c, eng_issue_vld, m_iss_vec()); end
            checks++; if (eng_issue_id !== m_cmd.id || eng_issue_op !== m_cmd.op) begin errors++; $display("FAIL rnd_idop@%0d got %h/%h exp %h/%h", c, eng_issue_id, eng_issue_op, m_cmd.id, m_cmd.op); end
            checks++; if (inflight !== IW'(m_count())) begin errors++; $display("FAIL rnd_inflight@%0d got %0d exp %0d", c, inflight, m_count()); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d got %b exp %b", c, err, m_err); end
            checks++; if (drained !== (m_stage == 2)) begin errors++; $display("FAIL rnd_drained@%0d got %b exp %b", c, drained, (m_stage == 2)); end
        end
        cmd_vld = 0; eng_done = '0; drain_req = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_done_reopen();
        test_done_and_accept();
        test_err();
        test_drain();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
